// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared types and opcode constants for the instruction encoder
package instr_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request channel and instruction-memory write port of the encoder
interface instr_encoder_if #(
  parameter int INSTRW  = 32,
  parameter int PCWIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [2:0]         fmt;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [31:0]        imm;
  logic               mem_stall;
  logic               mem_we;
  logic [PCWIDTH-1:0] mem_addr;
  logic [INSTRW-1:0]  mem_wdata;

  modport master (
    output in_valid, in_last, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, mem_stall,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_last, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, mem_stall,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_fifo.sv
// rtl/instr_encoder_fifo.sv - synchronous FIFO buffering encoded words ahead of the memory write port
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs field-level requests into RV32I words and writes them sequentially to memory
module instr_encoder
  import instr_pkg::*;
#(
  parameter int INSTRW     = 32,
  parameter int PCWIDTH    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PCWIDTH-1:0] start_addr,
  instr_encoder_if.slave     bus,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  enc_state_e         state;
  enc_state_e         state_nxt;
  logic [PCWIDTH-1:0] addr;
  logic [INSTRW-1:0]  word;
  logic [INSTRW-1:0]  fifo_head;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fmt_ok;
  logic               imm_bad;
  logic               accept;
  logic               push;
  logic               pop;
  logic               writing_state;

  always_comb begin
    word    = '0;
    fmt_ok  = 1'b1;
    imm_bad = 1'b0;
    case (bus.fmt)
      FMT_R: word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_I: word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_S: word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
      FMT_B: begin
        word    = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                   bus.imm[4:1], bus.imm[11], bus.opcode};
        imm_bad = bus.imm[0];
      end
      FMT_U: word = {bus.imm[31:12], bus.rd, bus.opcode};
      FMT_J: begin
        word    = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
        imm_bad = bus.imm[0];
      end
      default: fmt_ok = 1'b0;
    endcase
  end

  // Ready uses the pre-pop full flag, so a simultaneous write never frees a slot early.
  assign bus.in_ready  = (state == ST_RUN) & ~fifo_full;
  assign accept        = bus.in_valid & bus.in_ready;
  assign push          = accept & fmt_ok;
  assign writing_state = (state == ST_RUN) | (state == ST_DRAIN);
  assign bus.mem_we    = writing_state & ~fifo_empty & ~bus.mem_stall;
  assign pop           = bus.mem_we;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = fifo_head;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);

  instr_fifo #(
    .WIDTH (INSTRW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (word),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (accept && bus.in_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty || (fifo_count == CW'(1) && pop)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      err  <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      addr <= {start_addr[PCWIDTH-1:2], 2'b00};
      err  <= |start_addr[1:0];
    end else begin
      if (pop) addr <= addr + PCWIDTH'(4);
      if (accept && (!fmt_ok || imm_bad)) err <= 1'b1;
    end
  end
endmodule
